// File: rtl/bram_port_ctrl_pkg.sv
// Shared constants and types for the BRAM port request/response controller.
// BRAM_RD_LATENCY sets the depth of the read-return pipeline.
package bram_ctrl_pkg;

  localparam int BRAM_RD_LATENCY = 2;
  localparam int DEF_AWIDTH      = 12;
  localparam int DEF_DWIDTH      = 253;

  typedef struct packed {
    logic                  wr;
    logic [DEF_AWIDTH-1:0] addr;
    logic [DEF_DWIDTH-1:0] data;
  } req_t;

endpackage

// File: rtl/bram_port_ctrl_if.sv
// Request, response and BRAM-port signal bundle for one bram_port_ctrl instance.
// The slave modport is the controller view; the master modport is the requester/BRAM side.
interface bram_port_ctrl_if
  import bram_ctrl_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) ();

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds its payload stable until then, and ready never depends on valid.
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DWIDTH-1:0] resp_data;
  logic [AWIDTH-1:0] bram_address;
  logic [DWIDTH-1:0] bram_data;
  logic              bram_rden;
  logic              bram_wren;
  logic [DWIDTH-1:0] bram_q;

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, resp_ready, bram_q,
    output req_ready, resp_valid, resp_data, bram_address, bram_data, bram_rden, bram_wren
  );

  modport master (
    output req_valid, req_wr, req_addr, req_data, resp_ready, bram_q,
    input  req_ready, resp_valid, resp_data, bram_address, bram_data, bram_rden, bram_wren
  );

endinterface

// File: rtl/bram_port_ctrl_resp_fifo.sv
// Circular response FIFO with naturally wrapping pointers and an occupancy count.
// Storage is left unreset; only pointers and count are cleared.
module bram_resp_fifo #(
  parameter int WIDTH = 253,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             pop_en;

  // A pop only retires an existing head, so pop while empty-but-pushing is ignored.
  assign pop_en    = pop && !empty;
  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop_en);
    end
  end

  overflow_a: assert property (@(posedge clock) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/bram_port_ctrl.sv
// Front end for one BRAM port: accepts read/write requests, drives the BRAM directly,
// tracks in-flight reads with a credit counter and buffers returned data in order.
module bram_port_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int RESP_DEPTH = 4
) (
  input logic             clock,
  input logic             reset_n,
  bram_port_ctrl_if.slave bus
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic                       acc;
  logic                       rd_acc;
  logic                       wr_acc;
  logic                       pop;
  logic [BRAM_RD_LATENCY-1:0] rd_pipe;
  logic [CW-1:0]              outstanding;
  logic [AWIDTH-1:0]          req_addr;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;

  // Credits cover reads still in the BRAM pipe plus those parked in the FIFO,
  // so a push can never land on a full FIFO.
  assign bus.req_ready = reset_n && (outstanding < CW'(RESP_DEPTH));

  assign acc      = bus.req_valid && bus.req_ready;
  assign rd_acc   = acc && !bus.req_wr;
  assign wr_acc   = acc && bus.req_wr;
  assign pop      = bus.resp_valid && bus.resp_ready;
  assign req_addr = bus.req_addr;

  assign bus.bram_rden    = rd_acc;
  assign bus.bram_wren    = wr_acc;
  assign bus.bram_address = req_addr;
  assign bus.bram_data    = bus.req_data;
  assign bus.resp_valid   = !fifo_empty;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_pipe     <= '0;
      outstanding <= '0;
    end else begin
      rd_pipe     <= {rd_pipe[BRAM_RD_LATENCY-2:0], rd_acc};
      outstanding <= outstanding + CW'(rd_acc) - CW'(pop);
    end
  end

  bram_resp_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_pipe[BRAM_RD_LATENCY-1]),
    .push_data (bus.bram_q),
    .pop       (pop),
    .head_data (bus.resp_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  credit_cover_a: assert property (@(posedge clock) disable iff (!reset_n)
    fifo_count <= outstanding);
  full_credit_a: assert property (@(posedge clock) disable iff (!reset_n)
    fifo_full |-> (outstanding == CW'(RESP_DEPTH)));

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Directed bench for bram_port_ctrl with a 2-cycle BRAM model and an in-order scoreboard.
module tb_bram_port_ctrl;
  import bram_ctrl_pkg::*;

  localparam int AW    = DEF_AWIDTH;
  localparam int DW    = DEF_DWIDTH;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  bram_port_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  bram_port_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .RESP_DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- BRAM model: 2-cycle registered read, holds q when idle ----------------
  logic [DW-1:0] bram_mem [4096];
  logic [DW-1:0] q_reg;
  logic          st_rd, st_wr;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  always @(posedge clock) begin
    if (st_wr) bram_mem[st_addr] <= st_data;
    if (st_rd) q_reg <= bram_mem[st_addr];
    st_rd   <= bus.bram_rden;
    st_wr   <= bus.bram_wren;
    st_addr <= bus.bram_address;
    st_data <= bus.bram_data;
  end
  assign bus.bram_q = q_reg;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [4096];
  logic [DW-1:0] last_resp;
  int            pop_cyc_q[$];

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (bus.resp_valid && bus.resp_ready) begin
        pop_cyc_q.push_back(cyc);
        last_resp = bus.resp_data;
        check("resp_pending", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) check("resp_data", bus.resp_data, exp_q.pop_front());
      end
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_wr) ref_mem[bus.req_addr] = bus.req_data;
        else            exp_q.push_back(ref_mem[bus.req_addr]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic rand_mode = 1'b0;

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_mode) bus.resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int bound, output logic ok, output int stalls);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    ok     = 1'b0;
    stalls = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
      step();
    end
    if (ok) step();
    bus.req_valid = 1'b0;
  endtask

  task automatic issue_chk(input string tag, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    logic ok;
    int   st;
    issue(wr, a, d, 60, ok, st);
    check(tag, DW'(ok), DW'(1));
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && !bus.resp_valid) break;
      step();
    end
    check("drain", DW'(exp_q.size()), DW'(0));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic ok;
    int   st;
    bus.req_valid  = 1'b1;
    bus.req_wr     = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;

    // Reset with a read offered: nothing may reach the BRAM.
    repeat (3) step();
    @(negedge clock);
    check("rst_req_ready", DW'(bus.req_ready), DW'(0));
    check("rst_resp_valid", DW'(bus.resp_valid), DW'(0));
    check("rst_rden", DW'(bus.bram_rden), DW'(0));
    step();
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", DW'(bus.req_ready), DW'(1));
    step();

    // Write then read: response exactly three cycles after accept.
    issue_chk("t1_wr", 1'b1, 12'h005, DW'('hA5));
    issue_chk("t1_rd", 1'b0, 12'h005, '0);
    @(negedge clock); check("t1_valid_t1", DW'(bus.resp_valid), DW'(0));
    step();
    @(negedge clock); check("t1_valid_t2", DW'(bus.resp_valid), DW'(0));
    step();
    @(negedge clock); check("t1_valid_t3", DW'(bus.resp_valid), DW'(1));
    check("t1_data", bus.resp_data, DW'('hA5));
    step();
    wait_drain();

    // Back-to-back reads at full rate.
    for (int i = 0; i < 8; i++) issue_chk("t2_wr", 1'b1, AW'(i), DW'(i + 1));
    wait_drain();
    pop_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, AW'(i), '0, 10, ok, st);
      check("t2_no_stall", DW'(st), DW'(0));
    end
    wait_drain();
    check("t2_resp_count", DW'(pop_cyc_q.size()), DW'(8));
    if (pop_cyc_q.size() == 8) check("t2_consecutive", DW'(pop_cyc_q[7] - pop_cyc_q[0]), DW'(7));

    // Consumer stalled: only RESP_DEPTH reads get credit.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue_chk("t3_acc", 1'b0, AW'(i), '0);
    @(negedge clock);
    check("t3_ready_low", DW'(bus.req_ready), DW'(0));
    check("t3_head_valid", DW'(bus.resp_valid), DW'(1));
    check("t3_head_data", bus.resp_data, DW'(1));
    step();
    issue(1'b0, 12'h004, '0, 6, ok, st);
    check("t3_fifth_blocked", DW'(ok), DW'(0));
    bus.resp_ready = 1'b1;
    issue_chk("t3_acc5", 1'b0, 12'h004, '0);
    issue_chk("t3_acc6", 1'b0, 12'h005, '0);
    wait_drain();

    // Read directly after a write to the same address sees new data.
    issue_chk("t4_wr0", 1'b1, 12'h010, DW'('h77));
    issue_chk("t4_wr1", 1'b1, 12'h010, DW'('h1));
    issue_chk("t4_rd", 1'b0, 12'h010, '0);
    wait_drain();
    check("t4_data", last_resp, DW'('h1));

    // Reset with two reads in flight.
    issue_chk("t5_wr0", 1'b1, 12'h020, DW'('h33));
    issue_chk("t5_wr1", 1'b1, 12'h021, DW'('h44));
    wait_drain();
    issue_chk("t5_rd0", 1'b0, 12'h020, '0);
    issue_chk("t5_rd1", 1'b0, 12'h021, '0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("t5_quiet", DW'(bus.resp_valid), DW'(0));
      step();
    end
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue_chk("t5_credit", 1'b0, 12'h021, '0);
    @(negedge clock);
    check("t5_ready_low", DW'(bus.req_ready), DW'(0));
    step();
    bus.resp_ready = 1'b1;
    wait_drain();
    check("t5_data", last_resp, DW'('h44));

    // Mixed traffic with a randomly stalling consumer.
    for (int i = 0; i < 32; i++) issue_chk("t6_init", 1'b1, AW'(i), rnd_data());
    wait_drain();
    rand_mode = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      repeat ($urandom_range(0, 1)) step();
      issue_chk("t6_acc", 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), rnd_data());
    end
    rand_mode = 1'b0;
    bus.resp_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
